// File: rtl/tour_cmd.sv
// Arbitrates the command processor between the UART and knight's-tour replay.
// Define TOUR_FANFARE_EN to issue horizontal tour moves with the fanfare opcode.
module tour_cmd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {StIdle, StVert, StHoldV, StHorz, StHoldH} state_e;

    localparam logic [3:0] OpVert = 4'h2;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] OpHorz = 4'h3;
`else
    localparam logic [3:0] OpHorz = 4'h2;
`endif
    localparam logic [7:0] HdgN     = 8'h00;
    localparam logic [7:0] HdgW     = 8'h3F;
    localparam logic [7:0] HdgS     = 8'h7F;
    localparam logic [7:0] HdgE     = 8'hBF;
    localparam logic [4:0] LastMove = 5'd23;
    localparam logic [7:0] RespDone = 8'hA5;
    localparam logic [7:0] RespBusy = 8'h5A;

    state_e     state_q, state_d;
    logic [4:0] mv_indx_q, mv_indx_d;
    logic [7:0] vert_hdg, horz_hdg;
    logic [3:0] vert_sq, horz_sq;
    logic       last_move;

    assign mv_indx   = mv_indx_q;
    assign last_move = (mv_indx_q == LastMove);

    // Anything other than a single set bit decodes to a zero-length move.
    always_comb begin
        vert_hdg = HdgN;
        vert_sq  = 4'd0;
        horz_hdg = HdgN;
        horz_sq  = 4'd0;
        case (move)
            8'h01: begin vert_hdg = HdgN; vert_sq = 4'd2; horz_hdg = HdgW; horz_sq = 4'd1; end
            8'h02: begin vert_hdg = HdgN; vert_sq = 4'd2; horz_hdg = HdgE; horz_sq = 4'd1; end
            8'h04: begin vert_hdg = HdgN; vert_sq = 4'd1; horz_hdg = HdgW; horz_sq = 4'd2; end
            8'h08: begin vert_hdg = HdgS; vert_sq = 4'd1; horz_hdg = HdgW; horz_sq = 4'd2; end
            8'h10: begin vert_hdg = HdgS; vert_sq = 4'd2; horz_hdg = HdgW; horz_sq = 4'd1; end
            8'h20: begin vert_hdg = HdgS; vert_sq = 4'd2; horz_hdg = HdgE; horz_sq = 4'd1; end
            8'h40: begin vert_hdg = HdgS; vert_sq = 4'd1; horz_hdg = HdgE; horz_sq = 4'd2; end
            8'h80: begin vert_hdg = HdgN; vert_sq = 4'd1; horz_hdg = HdgE; horz_sq = 4'd2; end
            default: begin
                vert_hdg = HdgN;
                vert_sq  = 4'd0;
                horz_hdg = HdgN;
                horz_sq  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        unique case (state_q)
            StIdle: begin
                if (start_tour) begin
                    state_d   = StVert;
                    mv_indx_d = 5'd0;
                end
            end
            StVert:  if (clr_cmd_rdy) state_d = StHoldV;
            StHoldV: if (send_resp) state_d = StHorz;
            StHorz:  if (clr_cmd_rdy) state_d = StHoldH;
            StHoldH: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StVert;
                        mv_indx_d = mv_indx_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
        resp    = RespBusy;
        unique case (state_q)
            StIdle: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RespDone;
            end
            StVert: begin
                cmd     = {OpVert, vert_hdg, vert_sq};
                cmd_rdy = 1'b1;
            end
            StHoldV: cmd = {OpVert, vert_hdg, vert_sq};
            StHorz: begin
                cmd     = {OpHorz, horz_hdg, horz_sq};
                cmd_rdy = 1'b1;
            end
            StHoldH: begin
                cmd  = {OpHorz, horz_hdg, horz_sq};
                resp = last_move ? RespDone : RespBusy;
            end
            default: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RespDone;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: stimulus queues expected commands/responses,
// a negedge monitor pops and compares on every handshake.
module tb_tour_cmd;

`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] HO = 4'h3;
`else
    localparam logic [3:0] HO = 4'h2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_tour = 1'b0;
    logic [7:0]  move = 8'h00;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] cmd;
        logic [4:0]  idx;
        logic        chk;
    } exp_t;

    exp_t       cq[$];
    logic [7:0] rq[$];

    logic [7:0]  mv_tab[10];
    logic [15:0] v_tab[10];
    logic [11:0] h_tab[10];

    tour_cmd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_rdy && clr_cmd_rdy) begin
                if (cq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cmd_unexpected: got %h, expected none", cmd);
                end else begin
                    exp_t e;
                    e = cq.pop_front();
                    check("cmd", 32'(cmd), 32'(e.cmd));
                    if (e.chk) check("cmd_idx", 32'(mv_indx), 32'(e.idx));
                end
            end
            if (send_resp && !clr_cmd_rdy) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got %h, expected none", resp);
                end else begin
                    logic [7:0] r;
                    r = rq.pop_front();
                    check("resp", 32'(resp), 32'(r));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        for (int k = 0; k < 20 && !cmd_rdy; k++) tick();
        check("rdy_timeout", 32'(cmd_rdy), 32'd1);
    endtask

    task automatic handshake(input bit both);
        wait_rdy();
        clr_cmd_rdy = 1'b1;
        send_resp   = both;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        check("hold_rdy", 32'(cmd_rdy), 32'd0);
    endtask

    task automatic pulse_resp();
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
    endtask

    task automatic start(input logic [7:0] m);
        move       = m;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        check("start_idx", 32'(mv_indx), 32'd0);
    endtask

    task automatic play_move(input int i, input logic [7:0] m, input logic [15:0] ev,
                             input logic [15:0] eh, input bit both, input bit ign);
        move = m;
        check("mv_indx", 32'(mv_indx), 32'(i));
        cq.push_back({ev, 5'(i), 1'b1});
        handshake(both);
        if (both) begin
            check("both_idx", 32'(mv_indx), 32'(i));
            tick();
            check("both_stay", 32'(cmd_rdy), 32'd0);
        end
        if (ign) begin
            start_tour   = 1'b1;
            cmd_rdy_UART = 1'b1;
            cmd_UART     = 16'h2BF3;
            #1;
            check("ign_rdy", 32'(cmd_rdy), 32'd0);
            tick();
            start_tour   = 1'b0;
            cmd_rdy_UART = 1'b0;
            check("ign_idx", 32'(mv_indx), 32'(i));
            check("ign_hold", 32'(cmd_rdy), 32'd0);
        end
        rq.push_back(8'h5A);
        pulse_resp();
        cq.push_back({eh, 5'(i), 1'b1});
        handshake(1'b0);
        rq.push_back((i == 23) ? 8'hA5 : 8'h5A);
        pulse_resp();
    endtask

    initial begin
        mv_tab[0] = 8'h01; v_tab[0] = 16'h2002; h_tab[0] = 12'h3F1;
        mv_tab[1] = 8'h00; v_tab[1] = 16'h2000; h_tab[1] = 12'h000;
        mv_tab[2] = 8'h02; v_tab[2] = 16'h2002; h_tab[2] = 12'hBF1;
        mv_tab[3] = 8'h04; v_tab[3] = 16'h2001; h_tab[3] = 12'h3F2;
        mv_tab[4] = 8'h08; v_tab[4] = 16'h27F1; h_tab[4] = 12'h3F2;
        mv_tab[5] = 8'h10; v_tab[5] = 16'h27F2; h_tab[5] = 12'h3F1;
        mv_tab[6] = 8'h20; v_tab[6] = 16'h27F2; h_tab[6] = 12'hBF1;
        mv_tab[7] = 8'h40; v_tab[7] = 16'h27F1; h_tab[7] = 12'hBF2;
        mv_tab[8] = 8'h80; v_tab[8] = 16'h2001; h_tab[8] = 12'hBF2;
        mv_tab[9] = 8'h03; v_tab[9] = 16'h2000; h_tab[9] = 12'h000;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_idx", 32'(mv_indx), 32'd0);
        check("rst_resp", 32'(resp), 32'hA5);
        check("rst_rdy0", 32'(cmd_rdy), 32'd0);
        cmd_rdy_UART = 1'b1;
        #1;
        check("rst_rdy1", 32'(cmd_rdy), 32'd1);
        cmd_rdy_UART = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // UART pass-through in idle
        cmd_UART     = 16'h2BF3;
        cmd_rdy_UART = 1'b1;
        #1;
        check("uart_cmd", 32'(cmd), 32'h2BF3);
        check("uart_rdy", 32'(cmd_rdy), 32'd1);
        cq.push_back({16'h2BF3, 5'd0, 1'b0});
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;

        // Tour 1: every decode plus invalid moves, overlap and mid-tour ignore
        start(mv_tab[0]);
        for (int i = 0; i < 24; i++)
            play_move(i, mv_tab[i % 10], v_tab[i % 10], {HO, h_tab[i % 10]}, i == 3, i == 5);
        check("t1_resp", 32'(resp), 32'hA5);
        check("t1_rdy", 32'(cmd_rdy), 32'd0);
        check("t1_idx", 32'(mv_indx), 32'd23);

        // Tour 2: full replay of a single move
        tick();
        start(8'h40);
        for (int i = 0; i < 24; i++)
            play_move(i, 8'h40, 16'h27F1, {HO, 12'hBF2}, 1'b0, 1'b0);
        check("t2_resp", 32'(resp), 32'hA5);

        // Tour 3: reset while in HOLD_H at move 10
        tick();
        start(8'h80);
        for (int i = 0; i < 10; i++)
            play_move(i, 8'h80, 16'h2001, {HO, 12'hBF2}, 1'b0, 1'b0);
        cq.push_back({16'h2001, 5'd10, 1'b1});
        handshake(1'b0);
        rq.push_back(8'h5A);
        pulse_resp();
        cq.push_back({HO, 12'hBF2, 5'd10, 1'b1});
        handshake(1'b0);
        check("pre_rst_idx", 32'(mv_indx), 32'd10);
        #1 rst_n = 1'b0;
        #1;
        check("abort_idx", 32'(mv_indx), 32'd0);
        check("abort_resp", 32'(resp), 32'hA5);
        check("abort_rdy", 32'(cmd_rdy), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("abort_quiet", 32'(cmd_rdy), 32'd0);
        check("abort_idx2", 32'(mv_indx), 32'd0);

        check("cq_empty", 32'(cq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
